// File: rtl/pixel_word_reader.sv
// rtl/pixel_word_reader.sv - fetches a run of DLX data-memory words and streams them
// out as little-endian 8-bit pixels over a valid/ready handshake.
module pixel_word_reader #(
   parameter int ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE_ADDR,
   input  logic [ADDR_W:0]   NUM_WORDS,
   output logic              MEM_REQ,
   output logic [ADDR_W-1:0] MEM_ADDR,
   input  logic              MEM_ACK,
   input  logic [31:0]       MEM_DATA,
   output logic              PIX_VALID,
   output logic [7:0]        PIX_DATA,
   output logic              PIX_LAST,
   input  logic              PIX_READY,
   output logic              BUSY,
   output logic              DONE
);

   typedef enum logic [1:0] {IDLE, REQ, UNPACK, FIN} state_t;

   localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   logic [31:0]       word;
   logic [1:0]        idx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;

   assign MEM_ADDR = addr;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         word      <= '0;
         idx       <= '0;
         addr      <= '0;
         remaining <= '0;
         MEM_REQ   <= 1'b0;
         PIX_VALID <= 1'b0;
         PIX_DATA  <= '0;
         PIX_LAST  <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               if (START) begin
                  BUSY <= 1'b1;
                  if (NUM_WORDS != '0) begin
                     addr      <= BASE_ADDR;
                     remaining <= NUM_WORDS;
                     MEM_REQ   <= 1'b1;
                     state     <= REQ;
                  end else begin
                     DONE  <= 1'b1;
                     state <= FIN;
                  end
               end
            end
            REQ: begin
               if (MEM_ACK) begin
                  word      <= MEM_DATA;
                  idx       <= 2'd0;
                  MEM_REQ   <= 1'b0;
                  PIX_VALID <= 1'b1;
                  PIX_DATA  <= MEM_DATA[7:0];
                  PIX_LAST  <= 1'b0;
                  state     <= UNPACK;
               end
            end
            UNPACK: begin
               if (PIX_READY) begin
                  if (idx != 2'd3) begin
                     // Look one byte ahead so the registered pixel lines up with the new idx.
                     idx      <= idx + 2'd1;
                     PIX_DATA <= word[{idx + 2'd1, 3'b000} +: 8];
                     PIX_LAST <= (idx == 2'd2) && (remaining == REM_ONE);
                  end else begin
                     PIX_VALID <= 1'b0;
                     PIX_LAST  <= 1'b0;
                     if (remaining > REM_ONE) begin
                        remaining <= remaining - REM_ONE;
                        addr      <= addr + ADDR_ONE;
                        MEM_REQ   <= 1'b1;
                        state     <= REQ;
                     end else begin
                        DONE  <= 1'b1;
                        state <= FIN;
                     end
                  end
               end
            end
            FIN: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_word_reader.sv
// tb/tb_pixel_word_reader.sv - randomized self-checking bench for pixel_word_reader
// against a queue-based model of the expected pixel stream and memory traffic.
module tb_pixel_word_reader;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          START;
   logic [AW-1:0] BASE_ADDR;
   logic [AW:0]   NUM_WORDS;
   logic          MEM_REQ;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_ACK;
   logic [31:0]   MEM_DATA;
   logic          PIX_VALID;
   logic [7:0]    PIX_DATA;
   logic          PIX_LAST;
   logic          PIX_READY;
   logic          BUSY;
   logic          DONE;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [DEPTH];

   pixel_word_reader #(.ADDR_W(AW)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .BASE_ADDR(BASE_ADDR),
      .NUM_WORDS(NUM_WORDS), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
      .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .PIX_VALID(PIX_VALID),
      .PIX_DATA(PIX_DATA), .PIX_LAST(PIX_LAST), .PIX_READY(PIX_READY),
      .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // rmode: 0 ready always, 1 ready toggles 1/0, 2 random; delay < 0 picks 0..3 per word.
   task automatic do_run(input string name, input int base, input int n, input int rmode,
                         input int delay, input bit stray, input bit inject, input bit timing);
      logic [7:0]    exp_q[$];
      logic [7:0]    e;
      logic [31:0]   w;
      logic [7:0]    held_data;
      logic [AW-1:0] req_addr;
      logic [AW-1:0] exp_addr;
      int  cyc, waiting, words_req, first_req, last_hs, cur_delay;
      bit  hold, held_last, done_seen, rdy, req_active;
      for (int i = 0; i < n; i++) begin
         w = mem[(base + i) % DEPTH];
         for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      end
      cyc = 0; waiting = 0; words_req = 0; first_req = -1; last_hs = -1;
      hold = 0; held_last = 0; held_data = '0; done_seen = 0; req_active = 0; req_addr = '0;
      cur_delay = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
      BASE_ADDR = AW'(base);
      NUM_WORDS = (AW+1)'(n);
      START     = 1'b1;
      tick();
      START     = 1'b0;
      BASE_ADDR = AW'($urandom);
      NUM_WORDS = (AW+1)'($urandom);
      n_checks++;
      if (BUSY !== 1'b1 || MEM_REQ !== 1'b1) begin
         n_fail++;
         $display("FAIL %s start_latency: busy=%b mem_req=%b required 1,1", name, BUSY, MEM_REQ);
      end
      while (!done_seen && cyc < 600) begin
         if (hold) begin
            n_checks++;
            if (PIX_VALID !== 1'b1 || PIX_DATA !== held_data || PIX_LAST !== held_last) begin
               n_fail++;
               $display("FAIL %s hold_stable: valid=%b data=%h last=%b required 1,%h,%b",
                        name, PIX_VALID, PIX_DATA, PIX_LAST, held_data, held_last);
            end
         end
         if (DONE === 1'b1) begin
            n_checks++;
            if (exp_q.size() != 0 || cyc != last_hs + 1 || words_req != n) begin
               n_fail++;
               $display("FAIL %s done_point: cycle=%0d pending=%0d words=%0d required cycle=%0d pending=0 words=%0d",
                        name, cyc, exp_q.size(), words_req, last_hs + 1, n);
            end
            done_seen = 1;
            MEM_ACK = 1'b0; PIX_READY = 1'b0;
            break;
         end
         if (MEM_REQ === 1'b1) begin
            if (!req_active) begin
               exp_addr = AW'((base + words_req) % DEPTH);
               n_checks++;
               if (MEM_ADDR !== exp_addr || words_req >= n) begin
                  n_fail++;
                  $display("FAIL %s req_addr: addr=%0d word#%0d required addr=%0d within %0d words",
                           name, MEM_ADDR, words_req, exp_addr, n);
               end
               req_active = 1; req_addr = MEM_ADDR;
               if (first_req < 0) first_req = cyc;
            end else begin
               n_checks++;
               if (MEM_ADDR !== req_addr) begin
                  n_fail++;
                  $display("FAIL %s addr_stable: addr=%0d required %0d", name, MEM_ADDR, req_addr);
               end
            end
            if (waiting >= cur_delay) begin
               MEM_ACK = 1'b1; MEM_DATA = mem[MEM_ADDR];
               waiting = 0; words_req++; req_active = 0;
               cur_delay = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
            end else begin
               MEM_ACK = 1'b0; MEM_DATA = $urandom; waiting++;
            end
         end else begin
            MEM_ACK  = stray;
            MEM_DATA = stray ? 32'hFFFF_FFFF : $urandom;
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         PIX_READY = rdy;
         hold = 0;
         if (PIX_VALID === 1'b1) begin
            if (rdy) begin
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
               n_checks++;
               if (PIX_DATA !== e || PIX_LAST !== (exp_q.size() == 0)) begin
                  n_fail++;
                  $display("FAIL %s pixel: data=%h last=%b required %h,%b",
                           name, PIX_DATA, PIX_LAST, e, exp_q.size() == 0);
               end
               last_hs = cyc;
            end else begin
               hold = 1; held_data = PIX_DATA; held_last = PIX_LAST;
            end
         end
         START     = inject && cyc == 6;
         BASE_ADDR = (inject && cyc == 6) ? AW'(100) : AW'($urandom);
         NUM_WORDS = (inject && cyc == 6) ? (AW+1)'(5) : (AW+1)'($urandom);
         tick();
         cyc++;
      end
      START = 1'b0;
      n_checks++;
      if (!done_seen) begin
         n_fail++;
         $display("FAIL %s done_timeout: done never seen in %0d cycles, required within budget", name, cyc);
      end
      if (timing) begin
         n_checks++;
         if (last_hs - first_req + 1 != 5 * n) begin
            n_fail++;
            $display("FAIL %s run_cycles: got %0d required %0d", name, last_hs - first_req + 1, 5 * n);
         end
      end
      tick();
      MEM_ACK = 1'b0;
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || PIX_VALID !== 1'b0 || MEM_REQ !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_done: done=%b busy=%b valid=%b req=%b required 0,0,0,0",
                  name, DONE, BUSY, PIX_VALID, MEM_REQ);
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; START = 1'b0; BASE_ADDR = '0; NUM_WORDS = '0;
      MEM_ACK = 1'b0; MEM_DATA = '0; PIX_READY = 1'b0;
      #1;
      n_checks++;
      if ({MEM_REQ, MEM_ADDR, PIX_VALID, PIX_DATA, PIX_LAST, BUSY, DONE} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: req=%b addr=%h valid=%b data=%h last=%b busy=%b done=%b required all 0",
                  MEM_REQ, MEM_ADDR, PIX_VALID, PIX_DATA, PIX_LAST, BUSY, DONE);
      end
      tick(); tick();
      RESET_N = 1'b1;
      tick();
      n_checks++;
      if ({MEM_REQ, PIX_VALID, BUSY, DONE} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_release_idle: req=%b valid=%b busy=%b done=%b required 0",
                  MEM_REQ, PIX_VALID, BUSY, DONE);
      end
   endtask

   task automatic test_single_word();
      mem[5] = 32'hDDCC_BBAA;
      do_run("single_word", 5, 1, 0, 0, 0, 0, 1);
   endtask

   task automatic test_back_to_back();
      do_run("backpressure", 0, 3, 1, 0, 0, 0, 0);
      do_run("back_to_back", 3, 2, 0, 0, 0, 0, 1);
   endtask

   task automatic test_slow_wrap();
      do_run("slow_wrap", 1023, 2, 0, 3, 0, 0, 0);
   endtask

   task automatic test_zero_length();
      BASE_ADDR = AW'(7); NUM_WORDS = '0; START = 1'b1;
      tick();
      START = 1'b0;
      n_checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b1 || MEM_REQ !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_t1: done=%b busy=%b req=%b required 1,1,0", DONE, BUSY, MEM_REQ);
      end
      tick();
      n_checks++;
      if (DONE !== 1'b0 || BUSY !== 1'b0 || MEM_REQ !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_t2: done=%b busy=%b req=%b required 0,0,0", DONE, BUSY, MEM_REQ);
      end
   endtask

   task automatic test_ignored_start();
      do_run("ignored_start", 200, 2, 0, 0, 0, 1, 1);
   endtask

   task automatic test_reset_midrun();
      BASE_ADDR = AW'(300); NUM_WORDS = (AW+1)'(2); START = 1'b1;
      tick();
      START = 1'b0;
      MEM_ACK = 1'b1; MEM_DATA = mem[300];
      tick();
      MEM_ACK = 1'b0; PIX_READY = 1'b1;
      tick(); tick();
      n_checks++;
      if (PIX_VALID !== 1'b1 || PIX_DATA !== mem[300][23:16]) begin
         n_fail++;
         $display("FAIL midrun_byte2: valid=%b data=%h required 1,%h", PIX_VALID, PIX_DATA, mem[300][23:16]);
      end
      PIX_READY = 1'b0;
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if ({MEM_REQ, MEM_ADDR, PIX_VALID, PIX_DATA, PIX_LAST, BUSY, DONE} !== '0) begin
         n_fail++;
         $display("FAIL midrun_async_reset: req=%b addr=%h valid=%b data=%h last=%b busy=%b done=%b required all 0",
                  MEM_REQ, MEM_ADDR, PIX_VALID, PIX_DATA, PIX_LAST, BUSY, DONE);
      end
      tick();
      RESET_N = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_done: done=%b busy=%b required 0,0", DONE, BUSY);
         end
      end
      do_run("after_reset", 40, 1, 0, 0, 0, 0, 1);
   endtask

   task automatic test_stray_ack();
      MEM_ACK = 1'b1; MEM_DATA = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (MEM_REQ !== 1'b0 || PIX_VALID !== 1'b0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: req=%b valid=%b busy=%b required 0,0,0", MEM_REQ, PIX_VALID, BUSY);
         end
      end
      MEM_ACK = 1'b0;
      do_run("stray_ack", 500, 2, 2, 1, 1, 0, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++)
         do_run("random", int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), 2, -1, 1'($urandom_range(0, 1)), 0, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_slow_wrap();
      test_zero_length();
      test_ignored_start();
      test_reset_midrun();
      test_stray_ack();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pixel_word_reader.md
# pixel_word_reader

Reads a run of 32-bit words from the DLX data memory and emits them as a stream of 8-bit pixels for the sharpening datapath. It is the read-side counterpart of the 32-bit load-enabled word registers the processor uses to write packed pixels. Each fetched word is held in an internal 32-bit register and unpacked little-endian, four pixels per word, over a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 10, word-address width; run length and address wrap at 2^ADDR_W.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a run; sampled only in IDLE.
- BASE_ADDR  in  ADDR_W  first word address; latched on accepted START.
- NUM_WORDS  in  ADDR_W+1  number of words in the run; latched on accepted START.
- MEM_REQ  out  1  memory read request.
- MEM_ADDR  out  ADDR_W  word address of the current request.
- MEM_ACK  in  1  memory returns MEM_DATA this cycle; ignored unless MEM_REQ=1.
- MEM_DATA  in  32  read data, valid with MEM_ACK.
- PIX_VALID  out  1  PIX_DATA is valid.
- PIX_DATA  out  8  current pixel.
- PIX_LAST  out  1  current pixel is the final pixel of the run.
- PIX_READY  in  1  consumer accepts the pixel when PIX_VALID=1.
- BUSY  out  1  run in progress (state other than IDLE).
- DONE  out  1  one-cycle pulse at run completion.

## Operation
- FSM states: IDLE, REQ, UNPACK, FIN.
- IDLE: START=1 and NUM_WORDS>0 latches addr=BASE_ADDR and remaining=NUM_WORDS, then goes to REQ. START=1 and NUM_WORDS=0 goes to FIN with no memory access.
- REQ: MEM_REQ=1, with MEM_ADDR=addr held stable until MEM_ACK. On MEM_ACK, the FSM captures MEM_DATA into the word register, sets idx=0 and goes to UNPACK.
- UNPACK: PIX_VALID=1 and PIX_DATA=word[8*idx+7 : 8*idx]. Byte 0 is bits [7:0] and is emitted first.
  - A handshake (PIX_VALID & PIX_READY) with idx<3 increments idx.
  - A handshake with idx=3 and remaining>1 decrements remaining, sets addr=addr+1 (mod 2^ADDR_W) and goes to REQ.
  - A handshake with idx=3 and remaining=1 goes to FIN.
- PIX_LAST=1 only when in UNPACK with idx=3 and remaining=1.
- FIN: DONE=1 for exactly one cycle, then the FSM goes to IDLE.
- START is ignored in all states except IDLE. The latched BASE_ADDR and NUM_WORDS are unaffected by input changes during a run.
- While PIX_VALID=1 and PIX_READY=0, PIX_DATA and PIX_LAST hold stable. PIX_VALID never drops without a handshake.
- Reset at any time, including mid-run: asynchronously returns the FSM to IDLE. All outputs go to 0, the word register, idx, addr and remaining clear, and no DONE is emitted for the aborted run.

## Timing
- Reset values: MEM_REQ=0, MEM_ADDR=0, PIX_VALID=0, PIX_DATA=0, PIX_LAST=0, BUSY=0, DONE=0.
- START sampled at edge t: BUSY=1 and MEM_REQ=1 from t+1.
- MEM_ACK sampled at edge k: PIX_VALID=1 from k+1 with byte 0.
- With PIX_READY held at 1 and MEM_ACK returned in the same cycle as MEM_REQ, each word takes 5 cycles: 1 REQ + 4 UNPACK. A run of N words takes 5N cycles from the first REQ to the last handshake.
- DONE is asserted in the cycle after the final handshake. BUSY drops in the cycle after DONE.
- START with NUM_WORDS=0: DONE=1 at t+1, BUSY=1 for that one cycle only, and MEM_REQ stays 0.
- MEM_ACK outside REQ has no effect. MEM_REQ may stay high for any number of cycles awaiting MEM_ACK.

## Test plan
- Single word: BASE_ADDR=5, NUM_WORDS=1, memory[5]=0xDDCCBBAA, PIX_READY=1 -> MEM_ADDR=5, pixels 0xAA,0xBB,0xCC,0xDD, PIX_LAST only on 0xDD, DONE one cycle later, exactly 5 cycles from REQ to last handshake.
- Three words with backpressure: BASE_ADDR=0, NUM_WORDS=3, PIX_READY toggling 1/0 every cycle -> 12 pixels in order, PIX_DATA stable while ready=0, addresses 0,1,2 requested once each.
- Slow memory and address wrap: ADDR_W=10, BASE_ADDR=1023, NUM_WORDS=2, MEM_ACK delayed 3 cycles -> MEM_ADDR 1023 then 0, held stable until each ack, 8 pixels, then DONE.
- Zero length and ignored start: NUM_WORDS=0 -> DONE at t+1, no MEM_REQ. During a 2-word run, START with BASE_ADDR=100 -> no effect on the run.
- Reset mid-run: RESET_N low during UNPACK idx=2 -> all outputs 0 immediately. No DONE. A new START after release runs normally from its own BASE_ADDR.
- Stray ack: MEM_ACK=1 with MEM_DATA=0xFFFFFFFF while IDLE or UNPACK -> word register and pixel stream unchanged.
